lfsr_period_mon: RTL and testbench

- Downstream observer of the LFSR stage. Samples its 11-bit output on every cycle the LFSR advances.
- Latches a seed value, then counts samples until the seed recurs, and reports the measured period.
- Flags a lockup (all-zeros) or a timeout, and checks the period against the maximal length 2^n-1 for the selected width.
- Used in the LFSR-vs-counter comparison as on-chip self-check, replacing golden-file comparison.

---
 rtl/lfsr_pkg.sv | 19 +
 rtl/lfsr_period_mon.sv | 105 ++++++++++
 tb/tb_lfsr_period_mon.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared LFSR constants, mode and period-monitor state types, fault codes and width helpers.
package lfsr_pkg;
    localparam int MAX_W = 11;
    typedef enum logic [1:0] {MODE_8, MODE_9, MODE_10, MODE_11} lfsr_mode_t;
    typedef enum logic [2:0] {PM_IDLE, PM_CAPTURE, PM_MEASURE, PM_DONE, PM_FAULT} pmon_state_t;
    localparam logic [1:0] FLT_NONE    = 2'b00;
    localparam logic [1:0] FLT_LOCKUP  = 2'b01;
    localparam logic [1:0] FLT_TIMEOUT = 2'b10;
    localparam logic [1:0] FLT_STUCK   = 2'b11;
    function automatic int unsigned width_of(lfsr_mode_t m);
        return 32'd8 + 32'(m);
    endfunction
    function automatic int unsigned mask_of(lfsr_mode_t m);
        return (32'd1 << width_of(m)) - 32'd1;
    endfunction
    function automatic int unsigned max_period(lfsr_mode_t m);
        return (32'd1 << width_of(m)) - 32'd1;
    endfunction
endpackage

// File: rtl/lfsr_period_mon.sv
// lfsr_period_mon: measures the recurrence period of an LFSR stream and flags lockup/timeout.
// Define LFSR_PMON_STALL_EN to also flag a repeated consecutive sample (stuck, code 11).
module lfsr_period_mon #(
    parameter int MAX_W = 11,
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic             sample_en,
    input  logic [MAX_W-1:0] lfsr_in,
    input  logic             arm,
    input  logic             clear,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] period,
    output logic             period_ok,
    output logic             fault,
    output logic [1:0]       fault_code
);
    import lfsr_pkg::*;
    pmon_state_t      state;
    lfsr_mode_t       mode_q;
    logic [MAX_W-1:0] seed, v;
    logic [CNT_W-1:0] count, k, max_p;
    logic [1:0]       meas_flt;
    logic             stuck;
    assign v     = lfsr_in & MAX_W'(mask_of(mode_q));
    assign k     = count + CNT_W'(1);
    assign max_p = CNT_W'(max_period(mode_q));
`ifdef LFSR_PMON_STALL_EN
    logic [MAX_W-1:0] prev;
    assign stuck = v == prev;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            prev <= '0;
        else if (sample_en && (state == PM_CAPTURE || state == PM_MEASURE))
            prev <= v;
`else
    assign stuck = 1'b0;
`endif
    // k reaching 2^n means a full cycle of samples passed without the seed recurring
    assign meas_flt = v == '0 ? FLT_LOCKUP :
                      stuck ? FLT_STUCK :
                      k == max_p + CNT_W'(1) ? FLT_TIMEOUT : FLT_NONE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= PM_IDLE;
            mode_q     <= MODE_8;
            seed       <= '0;
            count      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            period     <= '0;
            period_ok  <= 1'b0;
            fault      <= 1'b0;
            fault_code <= FLT_NONE;
        end else if (clear) begin
            state      <= PM_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            period_ok  <= 1'b0;
            fault      <= 1'b0;
            fault_code <= FLT_NONE;
        end else if (arm) begin
            state      <= PM_CAPTURE;
            mode_q     <= lfsr_mode_t'(mode);
            busy       <= 1'b1;
            done       <= 1'b0;
            period_ok  <= 1'b0;
            fault      <= 1'b0;
            fault_code <= FLT_NONE;
        end else if (sample_en) begin
            case (state)
                PM_CAPTURE: begin
                    seed  <= v;
                    count <= '0;
                    if (v == '0) begin
                        state      <= PM_FAULT;
                        busy       <= 1'b0;
                        fault      <= 1'b1;
                        fault_code <= FLT_LOCKUP;
                    end else
                        state <= PM_MEASURE;
                end
                PM_MEASURE: begin
                    if (v == seed) begin
                        state     <= PM_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        period    <= k;
                        period_ok <= k == max_p;
                    end else if (meas_flt != FLT_NONE) begin
                        state      <= PM_FAULT;
                        busy       <= 1'b0;
                        fault      <= 1'b1;
                        fault_code <= meas_flt;
                    end else
                        count <= k;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lfsr_period_mon.sv
// tb_lfsr_period_mon: randomized self-checking bench against a sample-list reference model.
module tb_lfsr_period_mon;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic        sample_en = 1'b0;
    logic [10:0] lfsr_in = '0;
    logic        arm = 1'b0;
    logic        clear = 1'b0;
    logic        busy, done, period_ok, fault;
    logic [11:0] period;
    logic [1:0]  fault_code;
    int checks = 0;
    int failures = 0;
    int unsigned smp[$];

    lfsr_period_mon #(.MAX_W(11), .CNT_W(12)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sample_en(sample_en), .lfsr_in(lfsr_in),
        .arm(arm), .clear(clear), .busy(busy), .done(done), .period(period),
        .period_ok(period_ok), .fault(fault), .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int c);
        sample_en = 1'b0;
        repeat (c) begin
            lfsr_in = 11'($urandom);
            tick();
        end
    endtask

    // gs: 0 = back-to-back, 1 = random gaps, 2 = three idle cycles every fifth sample
    task automatic feed(input int start, input int cnt, input int gs);
        for (int i = 0; i < cnt; i++) begin
            if (gs == 1 && $urandom_range(3) == 0) idle($urandom_range(1, 3));
            if (gs == 2 && i % 5 == 4) idle(3);
            sample_en = 1'b1;
            lfsr_in = 11'(smp[start + i]);
            tick();
        end
        sample_en = 1'b0;
    endtask

    task automatic gen_lfsr(input int n, input int unsigned seed0);
        int unsigned s, taps, lsb;
        taps = n == 8 ? 32'hB8 : n == 9 ? 32'h110 : n == 10 ? 32'h240 : 32'h500;
        s = seed0;
        smp.delete();
        repeat ((1 << n) + 8) begin
            smp.push_back(s | (($urandom << n) & 32'h7FF));
            lsb = s & 1;
            s = s >> 1;
            if (lsb != 0) s = s ^ taps;
        end
    endtask

    task automatic gen_distinct(input int n, input int unsigned seed0, input int unsigned lead0, input int unsigned lead1);
        int unsigned v, prv;
        smp.delete();
        smp.push_back(seed0);
        if (lead0 != 0) begin
            smp.push_back(lead0);
            smp.push_back(lead1);
            smp.push_back(lead1);
        end
        prv = smp[smp.size() - 1];
        v = 2;
        while (smp.size() < (1 << n) + 12) begin
            if (v != seed0 && v != prv) begin
                smp.push_back(v);
                prv = v;
            end
            v = v + 1 >= (1 << n) ? 2 : v + 1;
        end
    endtask

    // Outcome of a measurement straight from the sample list: idx is the deciding sample
    task automatic ref_model(input int n, output int idx, output int code, output int per);
        int unsigned mask, seed, prv, v;
        mask = (1 << n) - 1;
        seed = smp[0] & mask;
        idx = -1; code = 0; per = 0;
        if (seed == 0) begin
            idx = 0; code = 1;
            return;
        end
        prv = seed;
        for (int i = 1; i < smp.size(); i++) begin
            v = smp[i] & mask;
            if (v == seed) begin idx = i; per = i; return; end
            if (v == 0) begin idx = i; code = 1; return; end
`ifdef LFSR_PMON_STALL_EN
            if (v == prv) begin idx = i; code = 3; return; end
`endif
            if (i == (1 << n)) begin idx = i; code = 2; return; end
            prv = v;
        end
    endtask

    task automatic measure(input int m, input int gs, input string tag);
        int n, idx, code, per;
        n = 8 + m;
        ref_model(n, idx, code, per);
        mode = 2'(m);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        mode = 2'($urandom);
        chk({tag, "_armed_busy"}, busy, 1);
        chk({tag, "_armed_done"}, done, 0);
        chk({tag, "_armed_fault"}, fault, 0);
        feed(0, idx, gs);
        chk({tag, "_pre_busy"}, busy, 1);
        feed(idx, 1, gs);
        chk({tag, "_done"}, done, code == 0);
        chk({tag, "_fault"}, fault, code != 0);
        chk({tag, "_code"}, fault_code, code);
        chk({tag, "_busy"}, busy, 0);
        if (code == 0) begin
            chk({tag, "_period"}, period, per);
            chk({tag, "_period_ok"}, period_ok, per == (1 << n) - 1);
        end
        feed(idx + 1, 3, gs);
        chk({tag, "_hold_done"}, done, code == 0);
        chk({tag, "_hold_code"}, fault_code, code);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_fault", fault, 0);
        chk("rst_code", fault_code, 0);
        chk("rst_period", period, 0);
        chk("rst_period_ok", period_ok, 0);
        rst_n = 1'b1;
        tick();
        gen_lfsr(8, 1);
        measure(0, 0, "m8");
        gen_lfsr(11, 1);
        measure(3, 0, "m11");
        measure(3, 1, "m11_rearm");
        smp.delete();
        smp.push_back(32'h600);
        repeat (8) smp.push_back($urandom_range(1, 511));
        measure(1, 1, "lockup");
        gen_distinct(8, 1, 0, 0);
        measure(0, 1, "timeout");
        gen_lfsr(8, 5);
        mode = 2'b00;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        feed(0, 41, 0);
        chk("mid_busy", busy, 1);
        arm = 1'b1;
        clear = 1'b1;
        tick();
        arm = 1'b0;
        clear = 1'b0;
        chk("clr_busy", busy, 0);
        chk("clr_done", done, 0);
        feed(41, 220, 1);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_fault", fault, 0);
        gen_lfsr(8, $urandom_range(1, 255));
        measure(0, 2, "gap");
        gen_distinct(8, 32'h11, 32'h22, 32'h5A);
        measure(0, 1, "stall");
        for (int t = 0; t < 4; t++) begin
            int m;
            m = $urandom_range(0, 2);
            gen_lfsr(8 + m, $urandom_range(1, (1 << (8 + m)) - 1));
            measure(m, 1, $sformatf("rnd%0d", t));
        end
        gen_lfsr(9, 3);
        mode = 2'b01;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        feed(0, 20, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_period", period, 0);
        #2;
        rst_n = 1'b1;
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
